// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit core: owns the program counter, the Start/Ack
// handshake, branch next-PC selection and the RUN-cycle watchdog.
module prog_sequencer #(
  parameter int unsigned T       = 10,
  parameter int unsigned W       = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned MAX_CYC = 4000,
  parameter int unsigned P0_ADDR = 0,
  parameter int unsigned P1_ADDR = 256,
  parameter int unsigned P2_ADDR = 512
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          BranchEZ,
  input  logic          BranchNZ,
  input  logic          BranchAlways,
  input  logic          Done_in,
  input  logic [W-1:0]  BranchTarget,
  input  logic [W-1:0]  CondVal,
  output logic [T-1:0]  ProgCtr,
  output logic [T-1:0]  ProgCtr_p1,
  output logic          Exec,
  output logic          Busy,
  output logic          Ack,
  output logic          Timeout,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [T-1:0]  Entry0   = T'(P0_ADDR);
  localparam logic [T-1:0]  Entry1   = T'(P1_ADDR);
  localparam logic [T-1:0]  Entry2   = T'(P2_ADDR);
  localparam logic [CW-1:0] LastCyc  = CW'(MAX_CYC - 1);

  state_e         state;
  logic           taken;
  logic [T-1:0]   entry_pc;
  logic [T-1:0]   branch_pc;

  // PC+1 doubles as the JAL link value, so it wraps silently at 2**T.
  assign ProgCtr_p1 = ProgCtr + T'(1);

  // Outputs decoded straight from the registered state.
  assign Exec = (state == StRun);
  assign Busy = (state == StLoad) || (state == StRun);
  assign Ack  = (state == StDone);

  // Branch decision and target; the page bits come from PC+1 to match the link.
  always_comb begin
    taken     = BranchAlways
              | (BranchEZ & (CondVal == '0))
              | (BranchNZ & (CondVal != '0));
    branch_pc = {ProgCtr_p1[T-1:W], BranchTarget};
  end

  // Entry-point select; ProgSel=3 aliases program 0.
  always_comb begin
    entry_pc = Entry0;
    unique case (ProgSel)
      2'd1:    entry_pc = Entry1;
      2'd2:    entry_pc = Entry2;
      default: entry_pc = Entry0;
    endcase
  end

  // Sequencer FSM with PC, cycle counter and timeout flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= StIdle;
      ProgCtr    <= '0;
      CycleCount <= '0;
      Timeout    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Start) begin
            state      <= StLoad;
            ProgCtr    <= entry_pc;
            CycleCount <= '0;
            Timeout    <= 1'b0;
          end
        end
        // One cycle for the instruction-ROM read; PC held.
        StLoad: state <= StRun;
        StRun: begin
          CycleCount <= CycleCount + CW'(1);
          if (Done_in) begin
            state   <= StDone;
            Timeout <= 1'b0;
          end else if (CycleCount == LastCyc) begin
            // The instruction in this cycle still executes; only the PC stops.
            state   <= StDone;
            Timeout <= 1'b1;
          end else if (taken) begin
            ProgCtr <= branch_pc;
          end else begin
            ProgCtr <= ProgCtr_p1;
          end
        end
        StDone: begin
          if (!Start) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed runs; the stimulus queues the expected PC of
// every executing cycle and the expected end-of-run record, a negedge monitor
// pops and compares them whenever Exec is high or Ack rises.
module tb_prog_sequencer;

  localparam int unsigned T  = 10;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    ProgSel;
  logic          BranchEZ, BranchNZ, BranchAlways, Done_in;
  logic [W-1:0]  BranchTarget, CondVal;
  logic [T-1:0]  ProgCtr, ProgCtr_p1;
  logic          Exec, Busy, Ack, Timeout;
  logic [CW-1:0] CycleCount;

  prog_sequencer #(
    .T(T), .W(W), .CW(CW), .MAX_CYC(8),
    .P0_ADDR(0), .P1_ADDR(256), .P2_ADDR(512)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
    .Done_in(Done_in), .BranchTarget(BranchTarget), .CondVal(CondVal),
    .ProgCtr(ProgCtr), .ProgCtr_p1(ProgCtr_p1), .Exec(Exec), .Busy(Busy),
    .Ack(Ack), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [CW-1:0] cyc;
    logic          tmo;
    logic [T-1:0]  pc;
  } done_rec_t;

  logic [T-1:0] exp_pc_q[$];
  done_rec_t    exp_done_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every executing instruction and every end-of-run.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (Exec) begin
        if (exp_pc_q.size() == 0) begin
          check("unexpected_exec", 32'(ProgCtr), 32'h0);
          check("unexpected_exec_flag", 32'(Exec), 32'h0);
        end else begin
          logic [T-1:0] e;
          e = exp_pc_q.pop_front();
          check("exec_pc", 32'(ProgCtr), 32'(e));
          check("exec_pc_p1", 32'(ProgCtr_p1), 32'(T'(e + T'(1))));
        end
      end
      if (Ack && !ack_prev) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_ack", 32'(Ack), 32'h0);
        end else begin
          done_rec_t d;
          d = exp_done_q.pop_front();
          check("done_cycles", 32'(CycleCount), 32'(d.cyc));
          check("done_timeout", 32'(Timeout), 32'(d.tmo));
          check("done_pc", 32'(ProgCtr), 32'(d.pc));
        end
      end
      ack_prev = Ack;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_flags();
    BranchEZ = 0; BranchNZ = 0; BranchAlways = 0; Done_in = 0;
    BranchTarget = '0; CondVal = '0;
  endtask

  // Start a run and check the LOAD cycle; returns positioned in RUN cycle 1.
  task automatic start_run(input logic [1:0] sel, input logic [T-1:0] entry);
    Start = 1; ProgSel = sel;
    tick();
    ProgSel = ~sel;  // must be ignored from here on
    check("load_pc", 32'(ProgCtr), 32'(entry));
    check("load_busy", 32'(Busy), 32'h1);
    check("load_exec", 32'(Exec), 32'h0);
    check("load_cyc", 32'(CycleCount), 32'h0);
    check("load_timeout", 32'(Timeout), 32'h0);
    tick();
    check("run_busy", 32'(Busy), 32'h1);
  endtask

  // One RUN cycle: the instruction at pc executes with the given decoder flags.
  task automatic step(input bit ez, input bit nz, input bit ba, input bit dn,
                      input logic [W-1:0] tgt, input logic [W-1:0] cond,
                      input logic [T-1:0] pc);
    exp_pc_q.push_back(pc);
    BranchEZ = ez; BranchNZ = nz; BranchAlways = ba; Done_in = dn;
    BranchTarget = tgt; CondVal = cond;
    tick();
    clear_flags();
  endtask

  task automatic plain(input logic [T-1:0] pc);
    step(0, 0, 0, 0, 8'h0, 8'h0, pc);
  endtask

  task automatic expect_done(input logic [CW-1:0] cyc, input logic tmo,
                             input logic [T-1:0] pc);
    done_rec_t d;
    d.cyc = cyc; d.tmo = tmo; d.pc = pc;
    exp_done_q.push_back(d);
  endtask

  // Bounded wait for Ack, then drop Start and confirm return to IDLE.
  task automatic finish_run();
    int n = 0;
    while (!Ack && n < 20) begin
      tick();
      n++;
    end
    check("ack_seen", 32'(Ack), 32'h1);
    Start = 0;
    tick();
    check("idle_ack", 32'(Ack), 32'h0);
    check("idle_busy", 32'(Busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    Reset = 1; Start = 0; ProgSel = 0;
    clear_flags();
    tick(); tick();
    Reset = 0;
    mon_en = 1'b1;
    check("rst_pc", 32'(ProgCtr), 32'h0);
    check("rst_cyc", 32'(CycleCount), 32'h0);
    check("rst_exec", 32'(Exec), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_ack", 32'(Ack), 32'h0);
    check("rst_timeout", 32'(Timeout), 32'h0);
    tick();
    check("idle_hold_busy", 32'(Busy), 32'h0);

    // Straight-line run from P1, DNE at 0x105.
    start_run(2'd1, 10'h100);
    for (int i = 0; i < 5; i++) plain(10'(10'h100 + i));
    expect_done(16'd6, 1'b0, 10'h105);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h105);
    check("ack_next_cycle", 32'(Ack), 32'h1);
    // Start held: stay in DONE with no rerun.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ack", 32'(Ack), 32'h1);
      check("hold_busy", 32'(Busy), 32'h0);
      check("hold_cyc", 32'(CycleCount), 32'd6);
    end
    finish_run();

    // Branch checks at 0x105, target 0x20.
    start_run(2'd1, 10'h100);
    for (int i = 0; i < 5; i++) plain(10'(10'h100 + i));
    step(0, 1, 0, 0, 8'h20, 8'h03, 10'h105);   // JNZ taken
    expect_done(16'd7, 1'b0, 10'h120);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h120);
    finish_run();

    start_run(2'd1, 10'h100);
    for (int i = 0; i < 5; i++) plain(10'(10'h100 + i));
    step(0, 1, 0, 0, 8'h20, 8'h00, 10'h105);   // JNZ not taken
    expect_done(16'd7, 1'b0, 10'h106);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h106);
    finish_run();

    start_run(2'd1, 10'h100);
    for (int i = 0; i < 5; i++) plain(10'(10'h100 + i));
    step(1, 0, 0, 0, 8'h20, 8'h00, 10'h105);   // JEZ taken
    expect_done(16'd7, 1'b0, 10'h120);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h120);
    finish_run();

    // Wrap at 0x3FF with no branch; ProgSel=2 entry 0x200.
    start_run(2'd2, 10'h200);
    step(0, 0, 1, 0, 8'hFF, 8'h0, 10'h200);    // -> 0x2FF
    plain(10'h2FF);                            // -> 0x300
    step(0, 0, 1, 0, 8'hFF, 8'h0, 10'h300);    // -> 0x3FF
    plain(10'h3FF);                            // -> 0x000
    expect_done(16'd5, 1'b0, 10'h000);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h000);
    finish_run();

    // JAL at 0x3FF: page taken from PC+1 = 0x000.
    start_run(2'd2, 10'h200);
    step(0, 0, 1, 0, 8'hFF, 8'h0, 10'h200);
    plain(10'h2FF);
    step(0, 0, 1, 0, 8'hFF, 8'h0, 10'h300);
    step(0, 0, 1, 0, 8'h10, 8'h0, 10'h3FF);    // -> 0x010
    expect_done(16'd5, 1'b0, 10'h010);
    step(0, 0, 0, 1, 8'h0, 8'h0, 10'h010);
    finish_run();

    // Watchdog: ProgSel=3 aliases entry 0, no DNE; 8 RUN cycles then stop.
    start_run(2'd3, 10'h000);
    for (int i = 0; i < 7; i++) plain(10'(i));
    expect_done(16'd8, 1'b1, 10'h007);
    plain(10'h007);
    check("wd_ack", 32'(Ack), 32'h1);
    finish_run();

    // DNE and BranchAlways together: DONE wins, PC held; Timeout cleared by new run.
    start_run(2'd0, 10'h000);
    expect_done(16'd1, 1'b0, 10'h000);
    step(0, 0, 1, 1, 8'h55, 8'h0, 10'h000);
    finish_run();

    // Reset in RUN aborts with no Ack.
    start_run(2'd0, 10'h000);
    plain(10'h000);
    plain(10'h001);
    exp_pc_q.push_back(10'h002);
    Reset = 1;
    tick();
    Reset = 0;
    check("abort_pc", 32'(ProgCtr), 32'h0);
    check("abort_exec", 32'(Exec), 32'h0);
    check("abort_ack", 32'(Ack), 32'h0);
    check("abort_busy", 32'(Busy), 32'h0);
    Start = 0;
    tick();
    tick();
    check("abort_stays_idle", 32'(Busy), 32'h0);

    check("pc_queue_empty", 32'(exp_pc_q.size()), 32'h0);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
